cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/cache_arbiter.sv | 142 ++++++++++++++
 tb/tb_cache_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, cache arbiter states and defaults.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int DSTREAK_MAX_DEFAULT = 3;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one RAM port between icache and dcache. dcache is favoured, but only for
// DSTREAK_MAX consecutive block grants while icache is waiting.
module cache_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = DSTREAK_MAX_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  // The streak counter is only 2 bits, so the limit is clamped to what it can hold.
  localparam logic [1:0] DSTREAK_LIM = (DSTREAK_MAX > 3) ? 2'd3 : 2'(DSTREAK_MAX);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_wcnt;
  logic       w_wcnt_next;
  logic [1:0] r_dstreak;
  logic [1:0] w_dstreak_next;
  logic       w_dreq;
  logic       w_access;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);

  assign iload = ramload;
  assign dload = ramload;

  // State, word counter and dcache streak registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_wcnt    <= 1'b0;
      r_dstreak <= 2'd0;
    end else begin
      r_state   <= w_state_next;
      r_wcnt    <= w_wcnt_next;
      r_dstreak <= w_dstreak_next;
    end
  end

  // Next-state: grant selection, block completion and abort handling.
  always_comb begin
    w_state_next   = r_state;
    w_wcnt_next    = r_wcnt;
    w_dstreak_next = r_dstreak;
    case (r_state)
      IDLE: begin
        if (w_dreq && ((r_dstreak < DSTREAK_LIM) || !iREN)) begin
          w_state_next = DGNT;
        end else if (iREN) begin
          w_state_next = IGNT;
        end else begin
          w_state_next = IDLE;
        end
      end
      IGNT: begin
        if (w_access) begin
          w_state_next   = IDLE;
          w_dstreak_next = 2'd0;
        end else if (!iREN) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = IGNT;
        end
      end
      DGNT: begin
        if (!w_dreq) begin
          w_state_next = IDLE;
          w_wcnt_next  = 1'b0;
        end else if (w_access) begin
          w_wcnt_next = ~r_wcnt;
          // Second word of the block closes the grant and counts toward the streak.
          if (r_wcnt) begin
            w_state_next = IDLE;
            if (r_dstreak < DSTREAK_LIM) begin
              w_dstreak_next = r_dstreak + 2'd1;
            end else begin
              w_dstreak_next = r_dstreak;
            end
          end else begin
            w_state_next = DGNT;
          end
        end else begin
          w_state_next = DGNT;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_wcnt_next  = 1'b0;
      end
    endcase
  end

  // RAM strobes, address/data steering and cache stalls for the current grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      IDLE: begin
        ramREN = 1'b0;
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = ~w_access;
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~w_access;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a transaction-level ownership model checked every cycle.
module tb_cache_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  int n_total = 0;
  int n_bad   = 0;

  // model: who owns the RAM (0 none, 1 icache, 2 dcache), words done in block, streak
  int m_owner  = 0;
  int m_words  = 0;
  int m_streak = 0;

  cache_arbiter #(.DSTREAK_MAX(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  // Per-cycle model check, then advance the model using the inputs the next edge will see.
  initial begin
    logic        e_rren, e_rwen, e_iwait, e_dwait, dreq, acc;
    logic [31:0] e_addr, e_store;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        m_owner = 0; m_words = 0; m_streak = 0;
      end
      acc  = (ramstate == ACCESS);
      dreq = dREN | dWEN;
      e_rren = 1'b0; e_rwen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
      e_iwait = 1'b1; e_dwait = 1'b1;
      if (m_owner == 1) begin
        e_rren = 1'b1; e_addr = iaddr; e_iwait = !acc;
      end else if (m_owner == 2) begin
        e_rwen = dWEN; e_rren = dREN && !dWEN; e_addr = daddr; e_store = dstore; e_dwait = !acc;
      end
      chk("m_ramREN", 32'(ramREN), 32'(e_rren));
      chk("m_ramWEN", 32'(ramWEN), 32'(e_rwen));
      chk("m_ramaddr", ramaddr, e_addr);
      if (m_owner != 1) chk("m_ramstore", ramstore, e_store);
      chk("m_iwait", 32'(iwait), 32'(e_iwait));
      chk("m_dwait", 32'(dwait), 32'(e_dwait));
      chk("m_iload", iload, ramload);
      chk("m_dload", dload, ramload);
      chk("m_dstreak", 32'(dut.r_dstreak), 32'(m_streak));
      chk("m_wcnt", 32'(dut.r_wcnt), 32'(m_words));
      if (nRST) begin
        if (m_owner == 0) begin
          if (dreq && (m_streak < 3 || !iREN)) begin
            m_owner = 2; m_words = 0;
          end else if (iREN) begin
            m_owner = 1;
          end
        end else if (m_owner == 1) begin
          if (acc) begin
            m_owner = 0; m_streak = 0;
          end else if (!iREN) begin
            m_owner = 0;
          end
        end else begin
          if (!dreq) begin
            m_owner = 0; m_words = 0;
          end else if (acc) begin
            m_words++;
            if (m_words == 2) begin
              m_owner = 0; m_words = 0;
              if (m_streak < 3) m_streak++;
            end
          end
        end
      end
    end
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
    at_neg();
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    tick(); tick();
    nRST = 1'b1;

    // icache read, RAM busy for two cycles then ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    at_neg(); chk("t1_idle_ren", 32'(ramREN), 32'd0);
    tick();
    at_neg(); chk("t1_ren", 32'(ramREN), 32'd1); chk("t1_addr", ramaddr, 32'h40);
    chk("t1_busy_iwait", 32'(iwait), 32'd1);
    tick(); tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    at_neg(); chk("t1_iwait", 32'(iwait), 32'd0); chk("t1_iload", iload, 32'hDEADBEEF);
    tick();
    iREN = 1'b0; ramstate = FREE;
    at_neg(); chk("t1_done_ren", 32'(ramREN), 32'd0);
    tick();

    // simultaneous requests: dcache block first, then icache
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
    tick();
    ramstate = ACCESS; ramload = 32'h11111111;
    at_neg(); chk("t2_ren", 32'(ramREN), 32'd1); chk("t2_addr0", ramaddr, 32'h100);
    chk("t2_dwait0", 32'(dwait), 32'd0); chk("t2_iwait0", 32'(iwait), 32'd1);
    tick();
    daddr = 32'h104; ramload = 32'h22222222;
    at_neg(); chk("t2_addr1", ramaddr, 32'h104); chk("t2_dwait1", 32'(dwait), 32'd0);
    chk("t2_dload", dload, 32'h22222222);
    tick();
    dREN = 1'b0; ramstate = FREE;
    tick();
    ramstate = ACCESS;
    at_neg(); chk("t2_iren", 32'(ramREN), 32'd1); chk("t2_iaddr", ramaddr, 32'h80);
    chk("t2_iwait", 32'(iwait), 32'd0);
    tick();
    iREN = 1'b0;
    at_neg(); chk("t2_streak", 32'(dut.r_dstreak), 32'd0);
    tick();

    // both held: three dcache blocks, then icache wins the fourth round
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400; ramstate = ACCESS;
    for (int k = 0; k < 13; k++) begin
      at_neg();
      if (k == 9) begin
        chk("t4_streak3", 32'(dut.r_dstreak), 32'd3);
        chk("t4_idle_ren", 32'(ramREN), 32'd0);
      end
      if (k == 10) begin
        chk("t4_iwait", 32'(iwait), 32'd0); chk("t4_iaddr", ramaddr, 32'h300);
        chk("t4_dwait", 32'(dwait), 32'd1);
      end
      if (k == 11) chk("t4_streak0", 32'(dut.r_dstreak), 32'd0);
      if (k == 12) begin
        chk("t4_dwait_again", 32'(dwait), 32'd0); chk("t4_daddr", ramaddr, 32'h400);
      end
      tick();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick(); tick();

    // write wins over read; BUSY keeps dwait high
    dREN = 1'b1; dWEN = 1'b1; dstore = 32'h5; daddr = 32'h200;
    tick();
    ramstate = BUSY;
    at_neg(); chk("t3_wen", 32'(ramWEN), 32'd1); chk("t3_ren", 32'(ramREN), 32'd0);
    chk("t3_store", ramstore, 32'h5); chk("t3_busy_dwait", 32'(dwait), 32'd1);
    tick();
    ramstate = ACCESS;
    tick(); tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick();

    // ERROR holds the icache grant; address follows mid-grant
    iREN = 1'b1; iaddr = 32'h600;
    tick();
    ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) iaddr = 32'h604;
      at_neg(); chk("t5_err_iwait", 32'(iwait), 32'd1);
      if (k == 1) chk("t5_addr_follow", ramaddr, 32'h604);
      tick();
    end
    ramstate = ACCESS;
    at_neg(); chk("t5_iwait", 32'(iwait), 32'd0); chk("t5_ren", 32'(ramREN), 32'd1);
    tick();
    iREN = 1'b0; ramstate = FREE;
    tick();

    // reset in the middle of a dcache write block
    dWEN = 1'b1; daddr = 32'h500; dstore = 32'h77; ramstate = ACCESS;
    tick(); tick();
    nRST = 1'b0;
    at_neg(); chk("t6_wen", 32'(ramWEN), 32'd0); chk("t6_ren", 32'(ramREN), 32'd0);
    chk("t6_wcnt", 32'(dut.r_wcnt), 32'd0); chk("t6_state", 32'(dut.r_state), 32'(IDLE));
    tick();
    nRST = 1'b1; dWEN = 1'b0; ramstate = FREE;
    tick();

    // icache drops its request before ACCESS
    iREN = 1'b1; iaddr = 32'h700; ramstate = BUSY;
    tick(); tick();
    iREN = 1'b0;
    at_neg(); chk("t7_still_ren", 32'(ramREN), 32'd1);
    tick();
    at_neg(); chk("t7_dropped_ren", 32'(ramREN), 32'd0);
    tick();

    // single-word dcache read aborted after one word
    dREN = 1'b1; daddr = 32'h800; ramstate = ACCESS;
    tick(); tick();
    dREN = 1'b0;
    at_neg(); chk("t8_wcnt1", 32'(dut.r_wcnt), 32'd1);
    tick();
    at_neg(); chk("t8_wcnt0", 32'(dut.r_wcnt), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
